// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rdy, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rdy, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32I IF stage plus IF/ID register: predict-not-taken sequential fetch over a
// request/ready memory port, a one-word hold buffer for stalls, and a drop state
// that swallows the response to a squashed request.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               processor_rst_n,
  input  logic               Flush_IF,
  input  logic               Stall_IF,
  input  logic               Stall_ID,
  input  logic               Flush_ID,
  input  logic               br_taken,
  input  logic [31:0]        br_targetE,
  fetch_stage_if.master      imem,
  output logic [31:0]        instrD,
  output logic [31:0]        pcD,
  output logic [31:0]        pc_plus4D,
  output logic               validD
);

  typedef enum logic [1:0] {
    ST_WAIT,  // request outstanding at req_addr
    ST_DROP,  // request outstanding but squashed; response is discarded
    ST_IDLE   // returned word parked in the buffer, no request
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] next_addr_q, next_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;

  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;

  logic        redirect;
  logic [31:0] target;
  logic        hold;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc;
  logic [31:0] drop_dest;

  assign redirect = Flush_IF | br_taken;
  assign target   = Flush_IF ? RESET_PC : br_targetE;
  assign hold     = Stall_IF | Stall_ID;

  // While in IDLE the buffered word's PC is req_addr_q itself, so no separate
  // buffer PC register is kept.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    next_addr_d   = next_addr_q;
    buf_instr_d   = buf_instr_q;
    deliver       = 1'b0;
    deliver_instr = imem.imem_rdata;
    deliver_pc    = req_addr_q;
    drop_dest     = redirect ? target : next_addr_q;

    unique case (state_q)
      ST_WAIT: begin
        if (imem.imem_rdy) begin
          if (redirect) begin
            req_addr_d = target;
          end else if (!hold) begin
            deliver    = 1'b1;
            req_addr_d = req_addr_q + 32'd4;
          end else begin
            buf_instr_d = imem.imem_rdata;
            state_d     = ST_IDLE;
          end
        end else if (redirect) begin
          next_addr_d = target;
          state_d     = ST_DROP;
        end
      end
      ST_DROP: begin
        next_addr_d = drop_dest;
        if (imem.imem_rdy) begin
          req_addr_d = drop_dest;
          state_d    = ST_WAIT;
        end
      end
      ST_IDLE: begin
        if (redirect) begin
          req_addr_d = target;
          state_d    = ST_WAIT;
        end else if (!hold) begin
          deliver       = 1'b1;
          deliver_instr = buf_instr_q;
          req_addr_d    = req_addr_q + 32'd4;
          state_d       = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    if (Flush_ID || (!Stall_ID && !deliver)) begin
      id_instr_d    = NOP_INSTR;
      id_pc_d       = 32'd0;
      id_pc_plus4_d = 32'd0;
      id_valid_d    = 1'b0;
    end else if (!Stall_ID) begin
      id_instr_d    = deliver_instr;
      id_pc_d       = deliver_pc;
      id_pc_plus4_d = deliver_pc + 32'd4;
      id_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge processor_rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!processor_rst_n) begin
      state_q       <= ST_WAIT;
      req_addr_q    <= RESET_PC;
      next_addr_q   <= RESET_PC;
      buf_instr_q   <= NOP_INSTR;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      id_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      next_addr_q   <= next_addr_d;
      buf_instr_q   <= buf_instr_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
    end
  end

  // Request is gated by reset so nothing is issued while the stage is held in reset.
  assign imem.imem_req  = processor_rst_n && (state_q != ST_IDLE);
  assign imem.imem_addr = req_addr_q;

  assign instrD    = id_instr_q;
  assign pcD       = id_pc_q;
  assign pc_plus4D = id_pc_plus4_q;
  assign validD    = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a fetch-stream model checked every cycle
// plus hand-computed expectations at the key points of each scenario.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Flush_IF, Stall_IF, Stall_ID, Flush_ID, br_taken;
  logic [31:0] br_targetE;
  logic        rdy;
  logic [31:0] instrD, pcD, pc_plus4D;
  logic        validD;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage_if bus ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  assign bus.imem_rdy   = rdy;
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk             (clk),
    .processor_rst_n (rst_n),
    .Flush_IF        (Flush_IF),
    .Stall_IF        (Stall_IF),
    .Stall_ID        (Stall_ID),
    .Flush_ID        (Flush_ID),
    .br_taken        (br_taken),
    .br_targetE      (br_targetE),
    .imem            (bus),
    .instrD          (instrD),
    .pcD             (pcD),
    .pc_plus4D       (pc_plus4D),
    .validD          (validD)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the fetch stream is "the address the next useful word comes from",
  // an optional squashed request in flight, and at most one parked word.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  logic [31:0] m_addr, m_next;
  bit          m_squashed;
  word_t       m_parked[$];
  logic [31:0] e_instr, e_pc, e_plus4;
  logic        e_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr = RESET_PC; m_next = RESET_PC; m_squashed = 0; m_parked.delete();
      e_instr = NOP_INSTR; e_pc = 0; e_plus4 = 0; e_valid = 0;
    end else begin
      automatic bit          redir = Flush_IF || br_taken;
      automatic logic [31:0] tgt   = Flush_IF ? RESET_PC : br_targetE;
      automatic bit          stall = Stall_IF || Stall_ID;
      automatic bit          got   = 0;
      automatic word_t       w;
      if (m_parked.size() != 0) begin
        if (redir) begin
          m_parked.delete();
          m_addr = tgt;
        end else if (!stall) begin
          w = m_parked.pop_front();
          got = 1;
          m_addr = w.pc + 32'd4;
        end
      end else if (m_squashed) begin
        if (redir) m_next = tgt;
        if (rdy) begin
          m_squashed = 0;
          m_addr = m_next;
        end
      end else if (rdy) begin
        w.pc = m_addr;
        w.instr = mem_word(m_addr);
        if (redir) m_addr = tgt;
        else if (!stall) begin
          got = 1;
          m_addr = m_addr + 32'd4;
        end else m_parked.push_back(w);
      end else if (redir) begin
        m_squashed = 1;
        m_next = tgt;
      end

      if (Flush_ID || (!Stall_ID && !got)) begin
        e_instr = NOP_INSTR; e_pc = 0; e_plus4 = 0; e_valid = 0;
      end else if (!Stall_ID) begin
        e_instr = w.instr; e_pc = w.pc; e_plus4 = w.pc + 32'd4; e_valid = 1;
      end
    end
  end

  always @(negedge clk) begin
    automatic logic e_req = rst_n && (m_parked.size() == 0);
    check("m_req", {31'd0, bus.imem_req}, {31'd0, e_req});
    if (e_req) check("m_addr", bus.imem_addr, m_addr);
    check("m_instrD", instrD, e_instr);
    check("m_pcD", pcD, e_pc);
    check("m_pc_plus4D", pc_plus4D, e_plus4);
    check("m_validD", {31'd0, validD}, {31'd0, e_valid});
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic clr();
    Flush_IF = 0; Stall_IF = 0; Stall_ID = 0; Flush_ID = 0; br_taken = 0;
  endtask

  initial begin
    logic [15:0] rdy_pat, stl_pat, br_pat;
    rdy_pat = 16'b1011_0011_1001_1101;
    stl_pat = 16'b0000_1100_0011_0000;
    br_pat  = 16'b0100_0000_1000_0100;
    rst_n = 0; rdy = 1; br_targetE = 0;
    clr();

    // 1: reset values, then back-to-back fetch
    nxt(); nxt();
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_instrD", instrD, NOP_INSTR);
    check("rst_validD", {31'd0, validD}, 32'd0);
    #2 rst_n = 1;
    #1 check("first_req", {31'd0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, 32'h0);
    nxt();
    check("seq_pc0", pcD, 32'h0);
    check("seq_instr0", instrD, 32'h5A00_0013);
    check("seq_valid0", {31'd0, validD}, 32'd1);
    check("seq_addr4", bus.imem_addr, 32'h4);
    nxt();
    check("seq_pc4", pcD, 32'h4);
    check("seq_addr8", bus.imem_addr, 32'h8);

    // 2: two wait cycles at 0x8
    rdy = 0;
    nxt(); check("wait1_addr", bus.imem_addr, 32'h8); check("wait1_valid", {31'd0, validD}, 32'd0);
    nxt(); check("wait2_addr", bus.imem_addr, 32'h8); check("wait2_valid", {31'd0, validD}, 32'd0);
    rdy = 1;
    nxt(); check("after_wait_pc", pcD, 32'h8); check("after_wait_addr", bus.imem_addr, 32'hC);

    // 3: stall while the word at 0xC returns
    Stall_IF = 1; Stall_ID = 1;
    repeat (3) begin
      nxt();
      check("stall_req", {31'd0, bus.imem_req}, 32'd0);
      check("stall_pcD", pcD, 32'h8);
    end
    clr();
    nxt();
    check("unstall_pc", pcD, 32'hC);
    check("unstall_instr", instrD, 32'h5A00_001F);
    check("unstall_addr", bus.imem_addr, 32'h10);
    nxt(); check("seq_pc10", pcD, 32'h10);

    // 4: branch while the request at 0x14 waits
    rdy = 0;
    nxt(); check("br_wait_addr", bus.imem_addr, 32'h14);
    br_taken = 1; br_targetE = 32'h100; Flush_ID = 1;
    nxt(); check("drop_addr", bus.imem_addr, 32'h14); check("drop_valid", {31'd0, validD}, 32'd0);
    clr();
    nxt(); check("drop_addr2", bus.imem_addr, 32'h14);
    rdy = 1;
    nxt(); check("redir_addr", bus.imem_addr, 32'h100); check("redir_valid", {31'd0, validD}, 32'd0);
    nxt(); check("redir_pc", pcD, 32'h100); check("redir_valid1", {31'd0, validD}, 32'd1);

    // 5: Flush_IF beats br_taken
    Flush_IF = 1; br_taken = 1; br_targetE = 32'h200; Flush_ID = 1;
    nxt(); check("flush_addr", bus.imem_addr, RESET_PC); check("flush_valid", {31'd0, validD}, 32'd0);
    clr();
    nxt(); check("flush_pc", pcD, RESET_PC);

    // 6: branch with a buffered word under stall
    Stall_IF = 1; Stall_ID = 1;
    nxt(); check("buf_req", {31'd0, bus.imem_req}, 32'd0);
    br_taken = 1; br_targetE = 32'h300; Flush_ID = 1;
    nxt();
    check("buf_redir_req", {31'd0, bus.imem_req}, 32'd1);
    check("buf_redir_addr", bus.imem_addr, 32'h300);
    check("buf_redir_valid", {31'd0, validD}, 32'd0);
    clr();
    nxt(); check("buf_redir_pc", pcD, 32'h300);

    // PC wrap at the top of the address space
    br_taken = 1; br_targetE = 32'hFFFF_FFFC; Flush_ID = 1;
    nxt(); clr();
    nxt();
    check("wrap_pc", pcD, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4D, 32'h0);
    check("wrap_addr", bus.imem_addr, 32'h0);

    // Mixed pattern of waits, stalls and branches, checked by the model
    for (int i = 0; i < 16; i++) begin
      rdy = rdy_pat[i]; Stall_IF = stl_pat[i]; Stall_ID = stl_pat[i];
      br_taken = br_pat[i]; Flush_ID = br_pat[i]; br_targetE = 32'h400 + 32'(i * 16);
      nxt();
    end
    clr(); rdy = 1;
    repeat (3) nxt();

    // Asynchronous reset in the middle of a wait
    rdy = 0;
    nxt(); nxt();
    #2 rst_n = 0;
    #1;
    check("async_req", {31'd0, bus.imem_req}, 32'd0);
    check("async_instr", instrD, NOP_INSTR);
    check("async_pc", pcD, 32'd0);
    check("async_plus4", pc_plus4D, 32'd0);
    check("async_valid", {31'd0, validD}, 32'd0);
    nxt();
    #2 rst_n = 1; rdy = 1;
    nxt(); check("rerun_pc", pcD, RESET_PC);
    repeat (3) nxt();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 5-stage RV32I pipeline, plus the IF/ID pipeline register.
- Generates the fetch PC and drives a request/ready instruction-memory handshake.
- Honours Stall_IF/Stall_ID/Flush_IF/Flush_ID from the hazard and reset unit.
- Applies static predict-not-taken: sequential fetch, with redirection on the EX-stage br_taken.
- A one-entry hold buffer keeps a returned word during a stall; a drop state discards responses to squashed requests.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset or Flush_IF
NOP_INSTR, 32'h0000_0013, instruction word placed in ID for bubbles (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
processor_rst_n  input  1  asynchronous active-low reset of the whole stage
Flush_IF  input  1  synchronous restart: refetch from RESET_PC, discard all fetch state
Stall_IF  input  1  hold PC/fetch state (load-use stall)
Stall_ID  input  1  hold IF/ID register
Flush_ID  input  1  load bubble into IF/ID (branch or reset)
br_taken  input  1  EX-stage taken branch/jump; redirect fetch
br_targetE  input  32  redirect target, word-aligned
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address; stable while imem_req high and imem_rdy low
imem_rdy  input  1  memory accepts and returns data this cycle; may be high in the request's first cycle
imem_rdata  input  32  instruction word, valid when imem_req & imem_rdy
instrD  output  32  IF/ID instruction
pcD  output  32  IF/ID PC
pc_plus4D  output  32  IF/ID PC+4
validD  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (processor_rst_n low, async):
  - state=WAIT; req_addr=RESET_PC; buf_valid=0.
  - instrD=NOP_INSTR; pcD=0; pc_plus4D=0; validD=0.
  - imem_req forced 0 while reset is low; first request is issued in the first cycle after release.
- imem_req = (state==WAIT || state==DROP). imem_addr = req_addr. A word is delivered in the same cycle imem_rdy is high.
- Redirect = Flush_IF (target RESET_PC) or br_taken (target br_targetE). Flush_IF beats br_taken; a redirect beats Stall_IF.
- State WAIT (request outstanding):
  - rdy & redirect: discard rdata; req_addr=target; stay WAIT.
  - rdy & !Stall_ID: deliver word to IF/ID (pcD=req_addr); req_addr+=4; stay WAIT.
  - rdy & Stall_ID: buffer rdata and req_addr; buf_valid=1; go IDLE.
  - !rdy & redirect: next_addr=target; go DROP (imem_addr unchanged).
  - !rdy otherwise: stay WAIT.
- State DROP:
  - rdy: discard data; req_addr=next_addr; go WAIT.
  - Further redirects overwrite next_addr.
  - Never delivers to ID.
- State IDLE (buffer full, no request):
  - redirect: buf_valid=0; req_addr=target; go WAIT.
  - !Stall_ID: deliver buffer; buf_valid=0; req_addr=buf_pc+4; go WAIT.
  - else hold.
- IF/ID register, priority Flush_ID > Stall_ID > load:
  - Flush_ID: bubble.
  - Stall_ID: hold all fields.
  - Otherwise: load the delivered word (validD=1), or a bubble if no word was delivered this cycle (memory wait, DROP, redirect cycle).
  - Bubble: instrD=NOP_INSTR, validD=0; pcD and pc_plus4D don't-care, driven 0.
- pc_plus4D = pcD+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- br_taken and Stall_IF/Stall_ID together (load-use in ID, branch in EX): redirect taken; ID flushed via Flush_ID; the stall has no effect on fetch.
- Word order is preserved: no instruction is delivered twice or skipped.

Test Plan:
1. Release reset with imem_rdy=1 constantly -> imem_addr 0,4,8,... on consecutive cycles; pcD 0,4,8 one cycle later, validD=1; during reset imem_req=0 and instrD=0x13.
2. imem_rdy low 2 cycles at addr 0x8 -> imem_addr held 0x8; two bubbles (validD=0) in ID; then pcD=0x8.
3. Stall_IF=Stall_ID=1 for 3 cycles while rdy returns word at 0xC -> state IDLE, imem_req=0; ID holds previous instr; after release pcD=0xC and next request at 0x10.
4. br_taken with br_targetE=0x100 while a request at 0x14 waits -> imem_addr stays 0x14 until rdy, data dropped, next imem_addr=0x100, pcD=0x100 with no 0x14 instruction in ID.
5. Flush_IF and br_taken (target 0x200) in the same cycle -> next fetch at RESET_PC; validD=0 that cycle.
6. br_taken together with Stall_ID=1 and a buffered word -> buffer discarded, fetch at target, ID gets bubble; async reset asserted mid-wait -> all outputs at reset values immediately.
